// File: rtl/ps2_keypad_pkg.sv
// ps2_keypad_pkg: shared scancode constants, receiver state encoding and
// the set-2 scancode to Chip-8 key lookup used by the keypad decoder.
package ps2_keypad_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Keypad codes, laid out like the physical 1234/QWER/ASDF/ZXCV block
    localparam logic [7:0] SC_K1 = 8'h16;
    localparam logic [7:0] SC_K2 = 8'h1E;
    localparam logic [7:0] SC_K3 = 8'h26;
    localparam logic [7:0] SC_KC = 8'h25;
    localparam logic [7:0] SC_K4 = 8'h15;
    localparam logic [7:0] SC_K5 = 8'h1D;
    localparam logic [7:0] SC_K6 = 8'h24;
    localparam logic [7:0] SC_KD = 8'h2D;
    localparam logic [7:0] SC_K7 = 8'h1C;
    localparam logic [7:0] SC_K8 = 8'h1B;
    localparam logic [7:0] SC_K9 = 8'h23;
    localparam logic [7:0] SC_KE = 8'h2B;
    localparam logic [7:0] SC_KA = 8'h1A;
    localparam logic [7:0] SC_K0 = 8'h22;
    localparam logic [7:0] SC_KB = 8'h21;
    localparam logic [7:0] SC_KF = 8'h2A;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } key_hit_t;

    // Map a scancode to a keypad index; hit=0 for codes outside the keypad
    function automatic key_hit_t key_lookup(input logic [7:0] sc);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = 4'h0;
        case (sc)
            SC_K0: r.idx = 4'h0;
            SC_K1: r.idx = 4'h1;
            SC_K2: r.idx = 4'h2;
            SC_K3: r.idx = 4'h3;
            SC_K4: r.idx = 4'h4;
            SC_K5: r.idx = 4'h5;
            SC_K6: r.idx = 4'h6;
            SC_K7: r.idx = 4'h7;
            SC_K8: r.idx = 4'h8;
            SC_K9: r.idx = 4'h9;
            SC_KA: r.idx = 4'hA;
            SC_KB: r.idx = 4'hB;
            SC_KC: r.idx = 4'hC;
            SC_KD: r.idx = 4'hD;
            SC_KE: r.idx = 4'hE;
            SC_KF: r.idx = 4'hF;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_keypad_rx.sv
// ps2_keypad_rx: PS/2 line synchroniser, ps2_clk glitch filter, 11-bit
// frame receiver with odd-parity check and inter-bit timeout. Emits the
// received byte with a one-cycle valid strobe, or a one-cycle error strobe.
module ps2_keypad_rx
    import ps2_keypad_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_vld,
    output logic       rx_err
);

    localparam int FC_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic            ps2_clk_p0, ps2_clk_p1, ps2_data_p0, ps2_data_p1;
    logic            flt_clk;
    logic [FC_W-1:0] flt_cnt;
    logic            strobe_p2, data_p2;

    rx_state_t       state, state_n;
    logic [2:0]      bit_cnt, bit_cnt_n;
    logic [7:0]      shreg, shreg_n;
    logic            par_bit, par_bit_n;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      rx_byte_n;
    logic            rx_vld_n, rx_err_n;

    // Two-flop synchronisers; idle-high reset so reset release is not an edge
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
        end else begin
            ps2_clk_p0  <= ps2_clk;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_data_p0 <= ps2_data;
            ps2_data_p1 <= ps2_data_p0;
        end
    end

    // Glitch filter: flip filtered clock after FILTER_LEN disagreeing samples; strobe on the 1->0 flip
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            flt_clk   <= 1'b1;
            flt_cnt   <= '0;
            strobe_p2 <= 1'b0;
            data_p2   <= 1'b1;
        end else begin
            strobe_p2 <= flt_clk & ~ps2_clk_p1 & (flt_cnt == FC_LAST);
            data_p2   <= ps2_data_p1;
            if (ps2_clk_p1 == flt_clk) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FC_LAST) begin
                flt_clk <= ps2_clk_p1;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + FC_W'(1);
            end
        end
    end

    // Frame FSM state and outputs
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state   <= RX_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            rx_byte <= '0;
            rx_vld  <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            par_bit <= par_bit_n;
            rx_byte <= rx_byte_n;
            rx_vld  <= rx_vld_n;
            rx_err  <= rx_err_n;
        end
    end

    // Timeout counter: held at zero while idle and on every strobe
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            to_cnt <= '0;
        end else if (strobe_p2 || state == RX_IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Next-state logic; a strobe takes priority over a coincident timeout
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_bit_n = par_bit;
        rx_byte_n = rx_byte;
        rx_vld_n  = 1'b0;
        rx_err_n  = 1'b0;
        if (strobe_p2) begin
            case (state)
                RX_IDLE: begin
                    if (!data_p2) begin
                        state_n   = RX_DATA;
                        bit_cnt_n = '0;
                    end
                end
                RX_DATA: begin
                    shreg_n   = {data_p2, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = RX_PARITY;
                end
                RX_PARITY: begin
                    par_bit_n = data_p2;
                    state_n   = RX_STOP;
                end
                RX_STOP: begin
                    if ((^shreg ^ par_bit) && data_p2) begin
                        rx_vld_n  = 1'b1;
                        rx_byte_n = shreg;
                    end else begin
                        rx_err_n = 1'b1;
                    end
                    state_n = RX_IDLE;
                end
                default: state_n = RX_IDLE;
            endcase
        end else if (state != RX_IDLE && to_cnt == TO_LAST) begin
            state_n  = RX_IDLE;
            rx_err_n = 1'b1;
        end
    end

endmodule

// File: rtl/ps2_keypad.sv
// ps2_keypad: PS/2 set-2 keyboard to Chip-8 hex keypad. Decodes E0/F0
// prefixes, maps keypad scancodes to key indices and keeps key_down.
// Optional macro PS2_ERR_COUNT_EN adds a saturating err_count output.
module ps2_keypad
    import ps2_keypad_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key_down,
    output logic        key_event,
    output logic [3:0]  key_code,
    output logic        key_pressed,
    output logic [7:0]  scancode,
    output logic        frame_err
`ifdef PS2_ERR_COUNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    logic     rx_vld_p1, rx_err_p1;
    logic     ext, brk;
    key_hit_t hit;

    ps2_keypad_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk     (clk),
        .res_n   (res_n),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .rx_byte (scancode),
        .rx_vld  (rx_vld_p1),
        .rx_err  (rx_err_p1)
    );

    assign frame_err = rx_err_p1;
    assign hit       = key_lookup(scancode);

    // Decode stage: prefix flags and key map; events only on a real key_down change
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ext         <= 1'b0;
            brk         <= 1'b0;
            key_down    <= '0;
            key_event   <= 1'b0;
            key_code    <= '0;
            key_pressed <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (rx_err_p1) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (rx_vld_p1) begin
                if (scancode == SC_EXT) begin
                    ext <= 1'b1;
                end else if (scancode == SC_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!ext && hit.hit && (key_down[hit.idx] == brk)) begin
                        key_down[hit.idx] <= ~brk;
                        key_event         <= 1'b1;
                        key_code          <= hit.idx;
                        key_pressed       <= ~brk;
                    end
                end
            end
        end
    end

`ifdef PS2_ERR_COUNT_EN
    // Saturating frame error counter
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            err_count <= '0;
        end else if (rx_err_p1 && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ps2_keypad.sv
// tb_ps2_keypad: directed PS/2 frames against ps2_keypad with hand-computed
// expectations. Bit timing and timeout are scaled down to keep runs short.
module tb_ps2_keypad;

    localparam int HALF = 10;   // clk cycles per PS/2 clock phase
    localparam int FLEN = 4;
    localparam int TOUT = 150;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key_down;
    logic        key_event;
    logic [3:0]  key_code;
    logic        key_pressed;
    logic [7:0]  scancode;
    logic        frame_err;
`ifdef PS2_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int ev_cnt   = 0;
    int err_seen = 0;
    logic [3:0] last_code = '0;
    logic       last_pressed = 1'b0;

    ps2_keypad #(
        .FILTER_LEN    (FLEN),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk        (clk),
        .res_n      (res_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_down   (key_down),
        .key_event  (key_event),
        .key_code   (key_code),
        .key_pressed(key_pressed),
        .scancode   (scancode),
        .frame_err  (frame_err)
`ifdef PS2_ERR_COUNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    // Pulse monitor sampled on the inactive edge
    always @(negedge clk) begin
        if (res_n) begin
            if (key_event) begin
                ev_cnt       <= ev_cnt + 1;
                last_code    <= key_code;
                last_pressed <= key_pressed;
            end
            if (frame_err) err_seen <= err_seen + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic good);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(good ? ~^b : ^b);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst key_down", key_down, 0);
        chk("rst key_event", key_event, 0);
        chk("rst key_code", key_code, 0);
        chk("rst key_pressed", key_pressed, 0);
        chk("rst scancode", scancode, 0);
        chk("rst frame_err", frame_err, 0);
        res_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single make of key 7
        send_frame(8'h1C, 1'b1);
        chk("make1c scancode", scancode, 8'h1C);
        chk("make1c key_down", key_down, 16'h0080);
        chk("make1c events", ev_cnt, 1);
        chk("make1c code", last_code, 7);
        chk("make1c pressed", last_pressed, 1);

        // Typematic repeat then break
        send_frame(8'h1C, 1'b1);
        chk("repeat events", ev_cnt, 1);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h1C, 1'b1);
        chk("break key_down", key_down, 16'h0000);
        chk("break events", ev_cnt, 2);
        chk("break pressed", last_pressed, 0);

        // Extended sequences are ignored, including an extended keypad code
        send_frame(8'hE0, 1'b1);
        send_frame(8'h75, 1'b1);
        send_frame(8'hE0, 1'b1);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h75, 1'b1);
        send_frame(8'hE0, 1'b1);
        send_frame(8'h1C, 1'b1);
        chk("ext events", ev_cnt, 2);
        chk("ext key_down", key_down, 16'h0000);
        send_frame(8'h22, 1'b1);
        chk("key0 key_down", key_down, 16'h0001);
        chk("key0 code", last_code, 0);
        chk("key0 events", ev_cnt, 3);

        // Parity error leaves key_down alone; later F0 is still honoured
        send_frame(8'h16, 1'b1);
        chk("key1 key_down", key_down, 16'h0003);
        send_frame(8'h16, 1'b0);
        chk("parity err seen", err_seen, 1);
        chk("parity key_down", key_down, 16'h0003);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h16, 1'b1);
        chk("brk after err key_down", key_down, 16'h0001);
        chk("brk after err events", ev_cnt, 5);
        chk("brk after err code", last_code, 1);

        // Error clears a pending break prefix
        send_frame(8'hF0, 1'b1);
        send_frame(8'h55, 1'b0);
        chk("err2 seen", err_seen, 2);
        chk("err2 scancode", scancode, 8'hF0);
        send_frame(8'h22, 1'b1);
        chk("brk cleared key_down", key_down, 16'h0001);
        chk("brk cleared events", ev_cnt, 5);

        // Stall mid-frame for longer than the timeout
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TOUT + 50) @(negedge clk);
        chk("timeout seen", err_seen, 3);
`ifdef PS2_ERR_COUNT_EN
        chk("err_count 3", err_count, 3);
`endif
        send_frame(8'h2A, 1'b1);
        chk("keyF key_down", key_down, 16'h8001);
        chk("keyF code", last_code, 15);

        // Short glitch with data low must not start a frame
        ps2_data = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (TOUT + 50) @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        chk("glitch no err", err_seen, 3);
        send_frame(8'h1A, 1'b1);
        chk("keyA key_down", key_down, 16'h8401);
        chk("keyA events", ev_cnt, 7);

        // Reset mid-frame clears everything at once
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        #2 res_n = 1'b0;
        #1;
        chk("midrst key_down", key_down, 0);
        chk("midrst scancode", scancode, 0);
        chk("midrst key_code", key_code, 0);
        chk("midrst key_pressed", key_pressed, 0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        res_n = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h1C, 1'b1);
        chk("post rst key_down", key_down, 16'h0080);
        chk("post rst code", last_code, 7);

`ifdef PS2_ERR_COUNT_EN
        for (int i = 0; i < 300; i++) send_frame(8'h33, 1'b0);
        chk("err_count sat", err_count, 255);
        chk("err seen 303", err_seen, 303);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
